conv1d_mc_core: RTL

//  Parametrised multi-channel 1D convolution core; next generation of the single-channel computing core.

---
 rtl/conv1d_mc_core.sv | 130 +++++++++++++
 1 files changed

// File: rtl/conv1d_mc_core.sv
// conv1d_mc_core: multi-channel 1D convolution, one shared K-tap kernel, NUM_CH lanes, 2-stage pipeline.
// Define CONV1D_SAT_EN to clamp lane results to OUT_W; otherwise results wrap to the low OUT_W bits.
module conv1d_mc_core #(
  parameter int DATA_W  = 16,
  parameter int KER_LEN = 3,
  parameter int NUM_CH  = 4,
  parameter int OUT_W   = 32,
  parameter int LEN_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         frame_len,
  input  logic [DATA_W-1:0]        ker_data,
  input  logic                     ker_valid,
  output logic                     ker_ready,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_CH*OUT_W-1:0]  data_out,
  output logic                     out_valid,
  output logic                     done,
  output logic                     busy
);
  localparam int ACC_W = 2*DATA_W + $clog2(KER_LEN);
  localparam int CW    = $clog2(KER_LEN+1);
  typedef enum logic [2:0] {IDLE, LOAD_KER, FILL, RUN, DRAIN, DONE} state_t;
  state_t                     r_state, w_next;
  logic [CW-1:0]              r_cnt;
  logic [LEN_W-1:0]           r_len, r_out_cnt;
  logic signed [DATA_W-1:0]   r_ker [KER_LEN];
  logic signed [DATA_W-1:0]   r_win [NUM_CH][KER_LEN];
  logic signed [DATA_W-1:0]   w_win [NUM_CH][KER_LEN];
  logic signed [2*DATA_W-1:0] r_prod [NUM_CH][KER_LEN];
  logic signed [ACC_W-1:0]    w_sum [NUM_CH];
  logic [OUT_W-1:0]           w_fmt [NUM_CH];
  logic                       r_v1, r_v2;
  logic [NUM_CH*OUT_W-1:0]    r_out;
  logic                       w_acc, w_tap, w_tap_last, w_fill_last, w_run_last, w_launch;
  assign ker_ready   = r_state == LOAD_KER;
  assign in_ready    = r_state == FILL || r_state == RUN;
  assign busy        = r_state != IDLE;
  assign done        = r_state == DONE;
  assign out_valid   = r_v2;
  assign data_out    = r_out;
  assign w_acc       = in_valid & in_ready;
  assign w_tap       = ker_valid & ker_ready;
  assign w_launch    = w_acc && r_state == RUN;
  assign w_tap_last  = w_tap && r_cnt == CW'(KER_LEN-1);
  assign w_fill_last = w_acc && r_state == FILL && r_cnt == CW'(KER_LEN-2);
  assign w_run_last  = w_launch && r_out_cnt == r_len - 1'b1;
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:     w_next = start ? LOAD_KER : IDLE;
      LOAD_KER: w_next = w_tap_last ? (r_len == '0 ? DONE : FILL) : LOAD_KER;
      FILL:     w_next = w_fill_last ? RUN : FILL;
      RUN:      w_next = w_run_last ? DRAIN : RUN;
      DRAIN:    w_next = r_v1 ? DRAIN : DONE;
      DONE:     w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end
  // newest sample enters at index 0; older samples move toward K-1
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_win[c][0] = $signed(data_in[c*DATA_W +: DATA_W]);
      for (int k = 1; k < KER_LEN; k++) w_win[c][k] = r_win[c][k-1];
    end
  end
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_sum[c] = '0;
      for (int k = 0; k < KER_LEN; k++) w_sum[c] = w_sum[c] + ACC_W'(r_prod[c][k]);
    end
  end
`ifdef CONV1D_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      w_fmt[c] = w_sum[c] > SAT_MAX ? OUT_W'(SAT_MAX) : w_sum[c] < SAT_MIN ? OUT_W'(SAT_MIN) : OUT_W'(w_sum[c]);
  end
`else
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) w_fmt[c] = OUT_W'(w_sum[c]);
  end
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_len     <= '0;
      r_out_cnt <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_out     <= '0;
      for (int k = 0; k < KER_LEN; k++) r_ker[k] <= '0;
      for (int c = 0; c < NUM_CH; c++)
        for (int k = 0; k < KER_LEN; k++) begin
          r_win[c][k]  <= '0;
          r_prod[c][k] <= '0;
        end
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && start) begin
        r_len     <= frame_len;
        r_cnt     <= '0;
        r_out_cnt <= '0;
        for (int c = 0; c < NUM_CH; c++)
          for (int k = 0; k < KER_LEN; k++) r_win[c][k] <= '0;
      end else if (w_tap) begin
        r_cnt <= w_tap_last ? '0 : r_cnt + 1'b1;
      end else if (w_acc && r_state == FILL) begin
        r_cnt <= r_cnt + 1'b1;
      end
      for (int k = 0; k < KER_LEN; k++)
        if (w_tap && r_cnt == CW'(k)) r_ker[k] <= $signed(ker_data);
      if (w_launch) r_out_cnt <= r_out_cnt + 1'b1;
      if (w_acc) r_win <= w_win;
      r_v1 <= w_launch;
      if (w_launch)
        for (int c = 0; c < NUM_CH; c++)
          for (int k = 0; k < KER_LEN; k++) r_prod[c][k] <= r_ker[k] * w_win[c][k];
      r_v2 <= r_v1;
      if (r_v1)
        for (int c = 0; c < NUM_CH; c++) r_out[c*OUT_W +: OUT_W] <= w_fmt[c];
    end
  end
endmodule
